multiport_register_file: RTL and testbench

- Next-generation integer register file for the phoeniX core.
- Generalised to READ_PORTS independent combinational read ports, with write-to-read bypass and optional hard-wired zero register.
- Adds a per-register pending (scoreboard) bit: the issue stage reserves a destination, writeback releases it.
- Sits between decode/issue (reads, reserves) and writeback (writes); read_ready tells the hazard unit whether an operand is usable.

---
 rtl/multiport_register_file.sv | 116 +++++++++++
 tb/tb_multiport_register_file.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/multiport_register_file.sv
// Integer register file with READ_PORTS combinational read ports, optional
// write-to-read bypass, optional hard-wired zero register, and a per-register
// pending (scoreboard) bit with a registered count of pending registers.
module multiport_register_file #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 5,
    parameter int READ_PORTS = 3,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [READ_PORTS-1:0]         read_enable,
    input  logic [READ_PORTS*DEPTH-1:0]   read_index,
    output logic [READ_PORTS*WIDTH-1:0]   read_data,
    output logic [READ_PORTS-1:0]         read_ready,
    input  logic                          write_enable,
    input  logic [DEPTH-1:0]              write_index,
    input  logic [WIDTH-1:0]              write_data,
    input  logic                          reserve_enable,
    input  logic [DEPTH-1:0]              reserve_index,
    input  logic                          flush,
    output logic [DEPTH:0]                pending_count
);

    localparam int NREGS = 1 << DEPTH;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [NREGS-1:0] pending_q, pending_d;
    logic [DEPTH:0]   count_q, count_d;

    logic wr_en;   // write that actually lands in the array
    logic set_en;  // reservation that actually marks a register pending
    logic inc, dec;

    // Qualify write/reserve strobes against the hard-wired zero register
    always_comb begin
        wr_en  = write_enable && !((ZERO_REG != 0) && (write_index == '0));
        set_en = reserve_enable && !((ZERO_REG != 0) && (reserve_index == '0));
    end

    // Next array contents: single writeback port
    always_comb begin
        regs_d = regs_q;
        if (wr_en)
            regs_d[write_index] = write_data;
    end

    // Next pending bits and count; flush beats everything, a same-index
    // reserve beats the write's release (the newer producer owns the register)
    always_comb begin
        pending_d = pending_q;
        count_d   = count_q;
        inc       = set_en && !pending_q[reserve_index];
        dec       = write_enable && pending_q[write_index]
                    && !(set_en && (reserve_index == write_index));
        if (flush) begin
            pending_d = '0;
            count_d   = '0;
        end else begin
            if (write_enable)
                pending_d[write_index] = 1'b0;
            if (set_en)
                pending_d[reserve_index] = 1'b1;
            count_d = count_q + (DEPTH+1)'(inc) - (DEPTH+1)'(dec);
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    assign pending_count = count_q;

    // Read ports: zero register, then bypass, then array with scoreboard
    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
        logic [DEPTH-1:0] idx;
        logic [WIDTH-1:0] rd_data;
        logic             rd_rdy;

        assign idx = read_index[p*DEPTH +: DEPTH];

        // Combinational operand select for this port
        always_comb begin
            rd_data = '0;
            rd_rdy  = 1'b0;
            if (read_enable[p]) begin
                if ((ZERO_REG != 0) && (idx == '0)) begin
                    rd_data = '0;
                    rd_rdy  = 1'b1;
                end else if ((BYPASS != 0) && write_enable && (write_index == idx)) begin
                    rd_data = write_data;
                    rd_rdy  = 1'b1;
                end else begin
                    rd_data = regs_q[idx];
                    rd_rdy  = !pending_q[idx];
                end
            end
        end

        assign read_data[p*WIDTH +: WIDTH] = rd_data;
        assign read_ready[p]               = rd_rdy;
    end

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench for multiport_register_file: one bypassing instance and one
// non-bypassing instance share all stimulus.
module tb_multiport_register_file;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  re;
    logic [14:0] ri;
    logic        we;
    logic [4:0]  wi;
    logic [31:0] wd;
    logic        rsv_en;
    logic [4:0]  rsv_i;
    logic        flush;

    logic [95:0] a_rd, b_rd;
    logic [2:0]  a_rdy, b_rdy;
    logic [5:0]  a_cnt, b_cnt;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    multiport_register_file #(.BYPASS(1)) dut_a (
        .clk(clk), .reset(reset),
        .read_enable(re), .read_index(ri),
        .read_data(a_rd), .read_ready(a_rdy),
        .write_enable(we), .write_index(wi), .write_data(wd),
        .reserve_enable(rsv_en), .reserve_index(rsv_i),
        .flush(flush), .pending_count(a_cnt)
    );

    multiport_register_file #(.BYPASS(0)) dut_b (
        .clk(clk), .reset(reset),
        .read_enable(re), .read_index(ri),
        .read_data(b_rd), .read_ready(b_rdy),
        .write_enable(we), .write_index(wi), .write_data(wd),
        .reserve_enable(rsv_en), .reserve_index(rsv_i),
        .flush(flush), .pending_count(b_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance past the next rising edge, landing away from it
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        re = '0; ri = '0; we = 0; wi = '0; wd = '0;
        rsv_en = 0; rsv_i = '0; flush = 0;

        // reset state
        repeat (2) @(posedge clk);
        #2;
        re = 3'b111;
        ri = {5'd31, 5'd2, 5'd1};
        #1;
        check("rst_p0", a_rd[31:0], 32'h0);
        check("rst_p1", a_rd[63:32], 32'h0);
        check("rst_p2", a_rd[95:64], 32'h0);
        check("rst_rdy", a_rdy, 3'b111);
        check("rst_cnt", a_cnt, 6'd0);
        reset = 0;
        tick;

        // write x5, then async reset mid-cycle wipes it
        we = 1; wi = 5'd5; wd = 32'hDEADBEEF;
        tick;
        we = 0; ri[4:0] = 5'd5;
        #1;
        check("x5_written", a_rd[31:0], 32'hDEADBEEF);
        reset = 1;
        #1;
        check("x5_async_rst_a", a_rd[31:0], 32'h0);
        check("x5_async_rst_b", b_rd[31:0], 32'h0);
        reset = 0;
        tick;

        // same-cycle write/read of x7
        we = 1; wi = 5'd7; wd = 32'h12345678; ri[4:0] = 5'd7;
        #1;
        check("byp_data_a", a_rd[31:0], 32'h12345678);
        check("byp_rdy_a", a_rdy[0], 1'b1);
        check("nobyp_old_b", b_rd[31:0], 32'h0);
        tick;
        we = 0;
        #1;
        check("nobyp_after_b", b_rd[31:0], 32'h12345678);

        // x0 write + reserve are ignored
        we = 1; wi = 5'd0; wd = 32'hFFFFFFFF; rsv_en = 1; rsv_i = 5'd0; ri[4:0] = 5'd0;
        #1;
        check("x0_byp_data", a_rd[31:0], 32'h0);
        check("x0_byp_rdy", a_rdy[0], 1'b1);
        tick;
        we = 0; rsv_en = 0;
        #1;
        check("x0_data_a", a_rd[31:0], 32'h0);
        check("x0_data_b", b_rd[31:0], 32'h0);
        check("x0_cnt", a_cnt, 6'd0);

        // reserve x3, x4, x3 again
        rsv_en = 1; rsv_i = 5'd3;
        tick;
        check("rsv3_cnt", a_cnt, 6'd1);
        rsv_i = 5'd4;
        tick;
        check("rsv4_cnt", a_cnt, 6'd2);
        rsv_i = 5'd3;
        tick;
        check("rsv3again_cnt", a_cnt, 6'd2);
        rsv_en = 0; ri[9:5] = 5'd3;
        #1;
        check("x3_pend_rdy", a_rdy[1], 1'b0);
        we = 1; wi = 5'd3; wd = 32'hA5;
        #1;
        check("x3_byp_rdy_a", a_rdy[1], 1'b1);
        check("x3_nobyp_rdy_b", b_rdy[1], 1'b0);
        tick;
        we = 0;
        #1;
        check("x3_data", a_rd[63:32], 32'hA5);
        check("x3_rdy", a_rdy[1], 1'b1);
        check("x3_cnt", a_cnt, 6'd1);

        // x9: same-cycle write + reserve while pending keeps it pending
        rsv_en = 1; rsv_i = 5'd9;
        tick;
        check("rsv9_cnt", a_cnt, 6'd2);
        we = 1; wi = 5'd9; wd = 32'h99;
        tick;
        we = 0; rsv_en = 0; ri[14:10] = 5'd9;
        #1;
        check("x9_same_cnt", a_cnt, 6'd2);
        check("x9_rdy_b", b_rdy[2], 1'b0);
        check("x9_data_b", b_rd[95:64], 32'h99);

        // write x4 while reserving x10
        we = 1; wi = 5'd4; wd = 32'h44; rsv_en = 1; rsv_i = 5'd10;
        tick;
        we = 0; rsv_en = 0; ri[4:0] = 5'd4; ri[9:5] = 5'd10;
        #1;
        check("w4r10_cnt", a_cnt, 6'd2);
        check("w4r10_rdy", a_rdy, 3'b001);
        check("x4_data", a_rd[31:0], 32'h44);

        // reserve x1..x6 on top of x9, x10
        rsv_en = 1;
        for (int i = 1; i <= 6; i++) begin
            rsv_i = 5'(i);
            tick;
        end
        rsv_en = 0;
        #1;
        check("rsv1to6_cnt", a_cnt, 6'd8);

        // flush beats reserve; write still lands
        flush = 1; rsv_en = 1; rsv_i = 5'd8; we = 1; wi = 5'd2; wd = 32'h55;
        tick;
        flush = 0; rsv_en = 0; we = 0;
        ri = {5'd9, 5'd2, 5'd8};
        #1;
        check("flush_cnt_a", a_cnt, 6'd0);
        check("flush_cnt_b", b_cnt, 6'd0);
        check("flush_rdy", a_rdy, 3'b111);
        check("flush_x2", a_rd[63:32], 32'h55);

        // disabled ports drive zero, not ready
        re = 3'b010;
        #1;
        check("dis_p0", a_rd[31:0], 32'h0);
        check("dis_p2", b_rd[95:64], 32'h0);
        check("dis_rdy", a_rdy, 3'b010);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
